// File: rtl/sign_narrower_pkg.sv
// Shared width-select encodings and widths for the immediate-field narrow/extend paths.
// The sign-extension path decodes in_sel with the same table.
package sign_narrower_pkg;

  localparam int DATA_W = 16;
  localparam int FIELD_W = 12;
  localparam int OVF_CNT_W = 8;

  typedef enum logic [1:0] {
    SEL_6  = 2'b00,
    SEL_8  = 2'b01,
    SEL_10 = 2'b10,
    SEL_12 = 2'b11
  } sel_t;

  function automatic logic [4:0] sel_width(input logic [1:0] sel);
    case (sel)
      SEL_6:   sel_width = 5'd6;
      SEL_8:   sel_width = 5'd8;
      SEL_10:  sel_width = 5'd10;
      default: sel_width = 5'd12;
    endcase
  endfunction

endpackage

// File: rtl/sign_narrower_core.sv
// Combinational fit check plus truncate/saturate mux for one 16-b word.
// A word fits N bits when data[15:N-1] is all zeros or all ones.
module narrow_core
  import sign_narrower_pkg::*;
#(
  parameter int DW = 16,
  parameter int OW = 12
) (
  input  logic [DW-1:0] data,
  input  logic [1:0]    sel,
  input  logic          sat_en,
  output logic [OW-1:0] field,
  output logic          ovf
);

  logic [4:0]    n;
  logic [DW-1:0] upper;
  logic [OW-1:0] mask;
  logic [OW-1:0] msb;
  logic          fit;

  always_comb begin
    n     = sel_width(sel);
    // Arithmetic shift leaves exactly the bits that must agree with the sign.
    upper = DW'($signed(data) >>> (n - 5'd1));
    fit   = (upper == '0) || (upper == '1);
    mask  = (OW'(1) << n) - OW'(1);
    msb   = OW'(1) << (n - 5'd1);
    ovf   = !fit;
    field = data[OW-1:0] & mask;
    if (!fit && sat_en) begin
      field = data[DW-1] ? msb : (msb - OW'(1));
    end
  end

endmodule

// File: rtl/sign_narrower.sv
// Two-stage valid/ready pipeline narrowing a 16-b value to a 6/8/10/12-b field,
// with a sticky saturating count of overflowing words delivered.
module sign_narrower
  import sign_narrower_pkg::*;
#(
  parameter int DW    = DATA_W,
  parameter int OW    = FIELD_W,
  parameter int CNT_W = OVF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic [1:0]       in_sel,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OW-1:0]    out_data,
  output logic [1:0]       out_sel,
  output logic             out_ovf,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             ovf_clr
);

  logic             s1_valid_q, s1_valid_d;
  logic [DW-1:0]    s1_data_q, s1_data_d;
  logic [1:0]       s1_sel_q, s1_sel_d;
  logic             s1_sat_q, s1_sat_d;

  logic             s2_valid_q, s2_valid_d;
  logic [OW-1:0]    s2_data_q, s2_data_d;
  logic [1:0]       s2_sel_q, s2_sel_d;
  logic             s2_ovf_q, s2_ovf_d;

  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] cnt_base;

  logic             s1_load, s2_load;
  logic [OW-1:0]    core_field;
  logic             core_ovf;

  narrow_core #(.DW(DW), .OW(OW)) u_core (
    .data   (s1_data_q),
    .sel    (s1_sel_q),
    .sat_en (s1_sat_q),
    .field  (core_field),
    .ovf    (core_ovf)
  );

  assign s2_load  = !s2_valid_q || out_ready;
  assign s1_load  = !s1_valid_q || s2_load;
  assign in_ready = s1_load;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s1_sel_d   = s1_sel_q;
    s1_sat_d   = s1_sat_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    s2_sel_d   = s2_sel_q;
    s2_ovf_d   = s2_ovf_q;
    if (s1_load) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_sel_d  = in_sel;
        s1_sat_d  = sat_en;
      end
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_data_d = core_field;
        s2_sel_d  = s1_sel_q;
        s2_ovf_d  = core_ovf;
      end
    end
  end

  // Clear takes effect first so a same-cycle overflow still counts once.
  always_comb begin
    cnt_base  = ovf_clr ? '0 : ovf_cnt_q;
    ovf_cnt_d = cnt_base;
    if (s2_valid_q && out_ready && s2_ovf_q && (cnt_base != '1)) begin
      ovf_cnt_d = cnt_base + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_sel_q   <= '0;
      s1_sat_q   <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sel_q   <= '0;
      s2_ovf_q   <= 1'b0;
      ovf_cnt_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s1_sel_q   <= s1_sel_d;
      s1_sat_q   <= s1_sat_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      s2_sel_q   <= s2_sel_d;
      s2_ovf_q   <= s2_ovf_d;
      ovf_cnt_q  <= ovf_cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_sel   = s2_sel_q;
  assign out_ovf   = s2_ovf_q;
  assign ovf_cnt   = ovf_cnt_q;

endmodule

// File: tb/tb_sign_narrower.sv
// Directed-vector bench for sign_narrower; inputs change 1 ns after the rising edge.
module tb_sign_narrower;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic        sat_en;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_data;
  logic [1:0]  out_sel;
  logic        out_ovf;
  logic [7:0]  ovf_cnt;
  logic        ovf_clr;

  int n_vec = 0;
  int n_err = 0;

  sign_narrower #(.DW(16), .OW(12), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .sat_en    (sat_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ovf   (out_ovf),
    .ovf_cnt   (ovf_cnt),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One word through an idle pipe with out_ready=1; checks 2-cycle latency and result.
  task automatic send_one(input string tag, input logic [15:0] d, input logic [1:0] s,
                          input logic sa, input logic [11:0] exp_dat, input logic exp_ovf);
    in_valid = 1'b1;
    in_data  = d;
    in_sel   = s;
    sat_en   = sa;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_lat1_valid"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_lat2_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp_dat));
    chk({tag, "_ovf"}, 32'(out_ovf), 32'(exp_ovf));
    chk({tag, "_sel"}, 32'(out_sel), 32'(s));
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_sel    = 2'b00;
    sat_en    = 1'b0;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sel", 32'(out_sel), 32'd0);
    chk("rst_out_ovf", 32'(out_ovf), 32'd0);
    chk("rst_ovf_cnt", 32'(ovf_cnt), 32'd0);
    reset = 1'b0;
    tick();

    // 8-b truncation
    send_one("t8_007f", 16'h007F, 2'b01, 1'b0, 12'h07F, 1'b0);
    send_one("t8_ff80", 16'hFF80, 2'b01, 1'b0, 12'h080, 1'b0);
    send_one("t8_0080", 16'h0080, 2'b01, 1'b0, 12'h080, 1'b1);
    // 6-b saturation
    send_one("s6_0100", 16'h0100, 2'b00, 1'b1, 12'h01F, 1'b1);
    send_one("s6_8000", 16'h8000, 2'b00, 1'b1, 12'h020, 1'b1);
    send_one("s6_ffe0", 16'hFFE0, 2'b00, 1'b1, 12'h020, 1'b0);
    // wider fields
    send_one("s12_0800", 16'h0800, 2'b11, 1'b1, 12'h7FF, 1'b1);
    send_one("t10_fe00", 16'hFE00, 2'b10, 1'b0, 12'h200, 1'b0);
    send_one("t12_f000", 16'hF000, 2'b11, 1'b0, 12'h000, 1'b1);
    tick();
    chk("cnt_after_directed", 32'(ovf_cnt), 32'd5);

    // Back-to-back stream of 8 words
    in_sel = 2'b01;
    sat_en = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        in_valid = 1'b1;
        in_data  = 16'(c * 3);
        chk("b2b_in_ready", 32'(in_ready), 32'd1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (c >= 1 && c <= 8) begin
        chk("b2b_valid", 32'(out_valid), 32'd1);
        chk("b2b_data", 32'(out_data), 32'((c - 1) * 3));
      end else begin
        chk("b2b_idle", 32'(out_valid), 32'd0);
      end
    end

    // Stall mid-stream
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    tick();
    in_data = 16'h0022;
    chk("stall_rdy_after1", 32'(in_ready), 32'd1);
    tick();
    in_data = 16'h0033;
    chk("stall_rdy_full", 32'(in_ready), 32'd0);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", 32'(out_data), 32'h011);
      chk("stall_sel", 32'(out_sel), 32'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("release_w1", 32'(out_data), 32'h022);
    tick();
    chk("release_w2_valid", 32'(out_valid), 32'd1);
    chk("release_w2", 32'(out_data), 32'h033);
    tick();
    chk("release_drained", 32'(out_valid), 32'd0);

    // Counter clear alone, then saturation after 300 overflows
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_alone", 32'(ovf_cnt), 32'd0);
    in_sel  = 2'b00;
    sat_en  = 1'b1;
    in_data = 16'h4000;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("cnt_saturated", 32'(ovf_cnt), 32'hFF);
    chk("sat_last_data", 32'(out_data), 32'h01F);

    // Clear on the same cycle as an overflow handshake
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("clr_hs_valid", 32'(out_valid), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("clr_with_hs", 32'(ovf_cnt), 32'd1);

    // Reset with both stages full and a word still offered
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_sel    = 2'b01;
    sat_en    = 1'b0;
    in_data   = 16'h0055;
    tick();
    in_data = 16'h0066;
    tick();
    chk("prerst_full", 32'(in_ready), 32'd0);
    in_data = 16'h0077;
    reset   = 1'b1;
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("rst_full_valid", 32'(out_valid), 32'd0);
    chk("rst_full_in_ready", 32'(in_ready), 32'd1);
    chk("rst_full_cnt", 32'(ovf_cnt), 32'd0);
    chk("rst_full_data", 32'(out_data), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rst_no_stale", 32'(out_valid), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
